// File: rtl/modbus_reg_engine.sv
// Modbus RTU function engine: FC03/FC04 reads into response DPRAM,
// FC06 single writes via handshake with timeout, own exception checks.
module modbus_reg_engine #(
  parameter int N_HOLD     = 8,
  parameter int N_INPUT    = 16,
  parameter int HOLD_BASE  = 1,
  parameter int INPUT_BASE = 1,
  parameter int MAX_QTY    = 32,
  parameter int DP_AW      = 7,
  parameter int WR_TIMEOUT = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [7:0]            req_func,
  input  logic [15:0]           req_addr,
  input  logic [15:0]           req_data,
  output logic                  busy,
  input  logic [16*N_HOLD-1:0]  hold_regs,
  input  logic [16*N_INPUT-1:0] input_regs,
  output logic                  dpram_wen,
  output logic [DP_AW-1:0]      dpram_addr,
  output logic [15:0]           dpram_wdata,
  output logic                  reg_wen,
  output logic [7:0]            reg_waddr,
  output logic [15:0]           reg_wdata,
  input  logic                  reg_w_done,
  input  logic                  reg_w_status,
  output logic                  rsp_valid,
  output logic [7:0]            rsp_func,
  output logic [7:0]            rsp_exception,
  output logic [7:0]            rsp_quantity
);

  localparam int TW = $clog2(WR_TIMEOUT + 1);
  localparam logic [16:0] L_HLO = 17'(HOLD_BASE);
  localparam logic [16:0] L_HHI = 17'(HOLD_BASE + N_HOLD - 1);
  localparam logic [16:0] L_ILO = 17'(INPUT_BASE);
  localparam logic [16:0] L_IHI = 17'(INPUT_BASE + N_INPUT - 1);
  localparam logic [15:0] L_MAXQ = 16'(MAX_QTY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_READ,
    S_WR_REQ,
    S_WR_WAIT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [7:0]    r_func;
  logic [15:0]   r_addr;
  logic [15:0]   r_data;
  logic [7:0]    r_off;
  logic [7:0]    r_qty;
  logic [7:0]    r_k;
  logic [TW-1:0] r_tmo;
  logic [7:0]    r_waddr;
  logic [15:0]   r_wdata;
  logic [7:0]    r_rsp_func;
  logic [7:0]    r_rsp_exc;
  logic [7:0]    r_rsp_qty;

  logic          w_rd;
  logic [16:0]   w_addr17;
  logic [16:0]   w_end;
  logic [16:0]   w_lo;
  logic [16:0]   w_hi;
  logic [7:0]    w_off;
  logic [7:0]    w_exc;
  logic [7:0]    w_ridx;
  logic [15:0]   w_word;
  logic          w_last;
  logic          w_tmo_hit;
  logic [7:0]    w_fin_exc;
  logic [7:0]    w_fin_qty;

  assign w_rd      = (r_func == 8'h03) || (r_func == 8'h04);
  assign w_addr17  = {1'b0, r_addr};
  assign w_end     = w_addr17 + {1'b0, r_data} - 17'd1;
  assign w_lo      = (r_func == 8'h04) ? L_ILO : L_HLO;
  assign w_hi      = (r_func == 8'h04) ? L_IHI : L_HHI;
  assign w_off     = r_addr[7:0] - w_lo[7:0];
  assign w_ridx    = r_off + r_k;
  assign w_last    = (r_k == r_qty - 8'd1);
  assign w_tmo_hit = (r_tmo == TW'(WR_TIMEOUT - 1));

  // Exception code, in priority order, from the latched request
  always_comb begin
    w_exc = 8'h00;
    if (!w_rd && r_func != 8'h06)
      w_exc = 8'h01;
    else if (w_rd && (r_data == 16'd0 || r_data > L_MAXQ))
      w_exc = 8'h03;
    else if (w_rd && (w_addr17 < w_lo || w_end > w_hi))
      w_exc = 8'h02;
    else if (r_func == 8'h06 &&
             (w_addr17 < L_HLO || w_addr17 > L_HHI))
      w_exc = 8'h02;
  end

  // Select the live bank word for the current read index
  always_comb begin
    w_word = 16'h0000;
    for (int i = 0; i < N_HOLD; i++)
      if (r_func == 8'h03 && w_ridx == 8'(i))
        w_word = hold_regs[16*i +: 16];
    for (int i = 0; i < N_INPUT; i++)
      if (r_func == 8'h04 && w_ridx == 8'(i))
        w_word = input_regs[16*i +: 16];
  end

  // Response code/quantity for whichever state is exiting to DONE
  always_comb begin
    w_fin_exc = 8'h00;
    w_fin_qty = 8'h00;
    unique case (r_state)
      S_CHECK: w_fin_exc = w_exc;
      S_READ:  w_fin_qty = r_qty;
      S_WR_WAIT: begin
        if (reg_w_done && !reg_w_status)
          w_fin_qty = 8'h01;
        else
          w_fin_exc = 8'h04;
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (req_valid) w_next = S_CHECK;
      S_CHECK:
        if (w_exc != 8'h00)       w_next = S_DONE;
        else if (r_func == 8'h06) w_next = S_WR_REQ;
        else                      w_next = S_READ;
      S_READ:
        if (w_last) w_next = S_DONE;
      S_WR_REQ:
        w_next = S_WR_WAIT;
      S_WR_WAIT:
        if (reg_w_done || w_tmo_hit) w_next = S_DONE;
      S_DONE:
        w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  // Strobes and DPRAM port decoded from state
  always_comb begin
    busy        = (r_state != S_IDLE);
    dpram_wen   = (r_state == S_READ);
    dpram_addr  = '0;
    dpram_wdata = 16'h0000;
    reg_wen     = (r_state == S_WR_REQ);
    rsp_valid   = (r_state == S_DONE);
    if (r_state == S_READ) begin
      dpram_addr  = DP_AW'(r_k);
      dpram_wdata = w_word;
    end
  end

  assign reg_waddr     = r_waddr;
  assign reg_wdata     = r_wdata;
  assign rsp_func      = r_rsp_func;
  assign rsp_exception = r_rsp_exc;
  assign rsp_quantity  = r_rsp_qty;

  // Request latch, counters and held response fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_func     <= 8'h00;
      r_addr     <= 16'h0000;
      r_data     <= 16'h0000;
      r_off      <= 8'h00;
      r_qty      <= 8'h00;
      r_k        <= 8'h00;
      r_tmo      <= '0;
      r_waddr    <= 8'h00;
      r_wdata    <= 16'h0000;
      r_rsp_func <= 8'h00;
      r_rsp_exc  <= 8'h00;
      r_rsp_qty  <= 8'h00;
    end else begin
      if (r_state == S_IDLE && req_valid) begin
        r_func <= req_func;
        r_addr <= req_addr;
        r_data <= req_data;
      end
      if (r_state == S_CHECK) begin
        r_off <= w_off;
        r_qty <= r_data[7:0];
        r_k   <= 8'h00;
        r_tmo <= '0;
        if (w_exc == 8'h00 && r_func == 8'h06) begin
          r_waddr <= w_off;
          r_wdata <= r_data;
        end
      end
      if (r_state == S_READ)
        r_k <= r_k + 8'd1;
      if (r_state == S_WR_WAIT)
        r_tmo <= r_tmo + 1'b1;
      if (r_state != S_DONE && w_next == S_DONE) begin
        r_rsp_func <= r_func;
        r_rsp_exc  <= w_fin_exc;
        r_rsp_qty  <= w_fin_qty;
      end
    end
  end

endmodule

// File: tb/tb_modbus_reg_engine.sv
// Bench for modbus_reg_engine: directed vector table, corner
// sequences and randomized requests against a behavioural model.
module tb_modbus_reg_engine;

  localparam int NH = 8;
  localparam int NI = 16;
  localparam int TO = 50;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic [7:0]      req_func = 8'h00;
  logic [15:0]     req_addr = 16'h0000;
  logic [15:0]     req_data = 16'h0000;
  logic            busy;
  logic [16*NH-1:0] hold_regs;
  logic [16*NI-1:0] input_regs;
  logic            dpram_wen;
  logic [6:0]      dpram_addr;
  logic [15:0]     dpram_wdata;
  logic            reg_wen;
  logic [7:0]      reg_waddr;
  logic [15:0]     reg_wdata;
  logic            reg_w_done = 1'b0;
  logic            reg_w_status = 1'b0;
  logic            rsp_valid;
  logic [7:0]      rsp_func;
  logic [7:0]      rsp_exception;
  logic [7:0]      rsp_quantity;

  logic [15:0] hv [NH];
  logic [15:0] iv [NI];

  for (genvar g = 0; g < NH; g++) begin : g_h
    assign hold_regs[16*g +: 16] = hv[g];
  end
  for (genvar g = 0; g < NI; g++) begin : g_i
    assign input_regs[16*g +: 16] = iv[g];
  end

  always #5 clk = ~clk;

  modbus_reg_engine #(
    .N_HOLD(NH), .N_INPUT(NI), .HOLD_BASE(1), .INPUT_BASE(1),
    .MAX_QTY(32), .DP_AW(7), .WR_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_func(req_func),
    .req_addr(req_addr), .req_data(req_data),
    .busy(busy),
    .hold_regs(hold_regs), .input_regs(input_regs),
    .dpram_wen(dpram_wen), .dpram_addr(dpram_addr),
    .dpram_wdata(dpram_wdata),
    .reg_wen(reg_wen), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .reg_w_done(reg_w_done), .reg_w_status(reg_w_status),
    .rsp_valid(rsp_valid), .rsp_func(rsp_func),
    .rsp_exception(rsp_exception), .rsp_quantity(rsp_quantity)
  );

  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    int f; int a; int d; int dly; int st; int inj; int exc; int qty;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic rand_banks();
    for (int i = 0; i < NH; i++) hv[i] = 16'($urandom);
    for (int i = 0; i < NI; i++) iv[i] = 16'($urandom);
  endtask

  // Spec-level outcome: exception code and response quantity
  function automatic void model(input int f, input int a, input int d,
                                input int dly, input int st,
                                output int exc, output int qty);
    int n;
    exc = 0;
    qty = 0;
    if (f != 3 && f != 4 && f != 6) exc = 1;
    else if (f != 6 && (d == 0 || d > 32)) exc = 3;
    else if (f == 6) begin
      if (a < 1 || a > NH) exc = 2;
      else if (dly >= 1 && dly <= TO && st == 0) qty = 1;
      else exc = 4;
    end else begin
      n = (f == 3) ? NH : NI;
      if (a < 1 || a + d - 1 > n) exc = 2;
      else qty = d;
    end
  endfunction

  task automatic run_req(input int f, input int a, input int dat,
                         input int dly, input int st, input int inj,
                         input int exc, input int qty,
                         input string nm);
    int c, nw, rw, wc, erc, idx;
    bit got, rd, wr;
    logic [15:0] ew;
    wr = (f == 6 && exc != 2);
    rd = (exc == 0 && f != 6);
    if (rd) erc = 2 + qty;
    else if (wr) erc = (dly >= 1 && dly <= TO) ? 3 + dly : 3 + TO;
    else erc = 2;
    @(negedge clk);
    req_valid = 1'b1;
    req_func = 8'(f);
    req_addr = 16'(a);
    req_data = 16'(dat);
    c = 0; nw = 0; rw = 0; wc = -1; got = 1'b0;
    while (!got && c < TO + 20) begin
      @(negedge clk);
      c++;
      req_valid = 1'b0;
      reg_w_done = 1'b0;
      reg_w_status = 1'b0;
      if (dpram_wen) begin
        check({nm, "/waddr"}, 32'(dpram_addr), nw);
        check({nm, "/wcyc"}, c, 2 + nw);
        if (rd && nw < qty) begin
          idx = a - 1 + nw;
          ew = (f == 3) ? hv[idx] : iv[idx];
          check({nm, "/wdata"}, 32'(dpram_wdata), 32'(ew));
        end
        nw++;
      end
      if (reg_wen) begin
        rw++;
        wc = c;
        check({nm, "/regwen_cyc"}, c, 2);
        check({nm, "/reg_waddr"}, 32'(reg_waddr), a - 1);
        check({nm, "/reg_wdata"}, 32'(reg_wdata), 32'(dat));
      end
      if (wr && wc > 0 && dly > 0 && c == wc + dly) begin
        reg_w_done = 1'b1;
        reg_w_status = st[0];
      end
      if (c == inj) begin
        check({nm, "/busy_drop"}, 32'(busy), 1);
        req_valid = 1'b1;
        req_func = 8'h05;
      end
      if (rsp_valid) begin
        got = 1'b1;
        check({nm, "/rsp_cyc"}, c, erc);
        check({nm, "/exc"}, 32'(rsp_exception), exc);
        check({nm, "/qty"}, 32'(rsp_quantity), qty);
        check({nm, "/func"}, 32'(rsp_func), f);
      end
      rand_banks();
    end
    reg_w_done = 1'b0;
    if (!got) check({nm, "/rsp_timeout"}, 0, 1);
    check({nm, "/nwen"}, nw, rd ? qty : 0);
    check({nm, "/nregwen"}, rw, wr ? 1 : 0);
    @(negedge clk);
    check({nm, "/busy_after"}, 32'(busy), 0);
    check({nm, "/exc_held"}, 32'(rsp_exception), exc);
  endtask

  initial begin
    int e, q, f, a, d, dly, st, sel, cnt;
    rand_banks();

    tbl.push_back('{3, 1, 3, 0, 0, 0, 0, 3});
    tbl.push_back('{4, 16, 1, 0, 0, 0, 0, 1});
    tbl.push_back('{4, 16, 2, 0, 0, 0, 2, 0});
    tbl.push_back('{4, 1, 0, 0, 0, 0, 3, 0});
    tbl.push_back('{4, 1, 33, 0, 0, 0, 3, 0});
    tbl.push_back('{5, 1, 1, 0, 0, 0, 1, 0});
    tbl.push_back('{0, 1, 1, 0, 0, 0, 1, 0});
    tbl.push_back('{6, 9, 7, 1, 0, 0, 2, 0});
    tbl.push_back('{6, 0, 5, 1, 0, 0, 2, 0});
    tbl.push_back('{6, 3, 1234, 2, 0, 0, 0, 1});
    tbl.push_back('{6, 3, 1234, 1, 1, 0, 4, 0});
    tbl.push_back('{6, 8, 5, 3, 0, 0, 0, 1});
    tbl.push_back('{3, 8, 1, 0, 0, 0, 0, 1});
    tbl.push_back('{3, 0, 1, 0, 0, 0, 2, 0});
    tbl.push_back('{3, 1, 8, 0, 0, 0, 0, 8});
    tbl.push_back('{3, 1, 9, 0, 0, 0, 2, 0});
    tbl.push_back('{4, 1, 32, 0, 0, 0, 2, 0});
    tbl.push_back('{4, 1, 16, 0, 0, 0, 0, 16});
    tbl.push_back('{3, 65535, 2, 0, 0, 0, 2, 0});
    tbl.push_back('{3, 1, 8, 0, 0, 4, 0, 8});

    repeat (3) @(negedge clk);
    check("rst/busy", 32'(busy), 0);
    check("rst/dpram_wen", 32'(dpram_wen), 0);
    check("rst/dpram_addr", 32'(dpram_addr), 0);
    check("rst/dpram_wdata", 32'(dpram_wdata), 0);
    check("rst/reg_wen", 32'(reg_wen), 0);
    check("rst/reg_waddr", 32'(reg_waddr), 0);
    check("rst/reg_wdata", 32'(reg_wdata), 0);
    check("rst/rsp_valid", 32'(rsp_valid), 0);
    check("rst/rsp_func", 32'(rsp_func), 0);
    check("rst/rsp_exc", 32'(rsp_exception), 0);
    check("rst/rsp_qty", 32'(rsp_quantity), 0);
    rst_n = 1'b1;

    foreach (tbl[i])
      run_req(tbl[i].f, tbl[i].a, tbl[i].d, tbl[i].dly, tbl[i].st,
              tbl[i].inj, tbl[i].exc, tbl[i].qty,
              $sformatf("vec%0d", i));

    // Write timeout, then a late done pulse must be ignored
    run_req(6, 3, 77, 0, 0, 0, 4, 0, "timeout");
    reg_w_done = 1'b1;
    @(negedge clk);
    reg_w_done = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cnt += int'(rsp_valid) + int'(busy);
    end
    check("late_done/activity", cnt, 0);
    check("late_done/exc_held", 32'(rsp_exception), 4);

    // Reset in the middle of a read
    @(negedge clk);
    req_valid = 1'b1;
    req_func = 8'h03;
    req_addr = 16'd1;
    req_data = 16'd8;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst/wen_before", 32'(dpram_wen), 1);
    rst_n = 1'b0;
    #1;
    check("midrst/wen", 32'(dpram_wen), 0);
    check("midrst/busy", 32'(busy), 0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cnt += int'(rsp_valid);
    end
    check("midrst/no_rsp", cnt, 0);
    rst_n = 1'b1;
    run_req(3, 2, 4, 0, 0, 0, 0, 4, "after_rst");

    // Randomized requests against the model
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4) f = 3;
      else if (sel < 7) f = 4;
      else if (sel < 9) f = 6;
      else f = $urandom_range(0, 255);
      a = $urandom_range(0, 20);
      if ($urandom_range(0, 9) == 0) a = $urandom_range(0, 65535);
      d = (f == 6) ? $urandom_range(0, 65535) : $urandom_range(0, 40);
      dly = $urandom_range(0, 6);
      st = $urandom_range(0, 1);
      model(f, a, d, dly, st, e, q);
      run_req(f, a, d, dly, st, 0, e, q, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
